// File: rtl/sisc_fetch_pc.sv
// SISC fetch stage: program counter, instruction register, instruction-memory
// request handshake with timeout, status register and branch-condition logic.
module sisc_fetch_pc #(
  parameter int unsigned PC_W    = 16,
  parameter int unsigned IR_W    = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic            i_clk,
  input  logic            i_rst_f,
  input  logic            i_pc_rst,
  input  logic            i_ir_load,
  input  logic            i_pc_write,
  input  logic            i_pc_sel,
  input  logic            i_br_sel,
  input  logic            i_stat_en,
  input  logic [3:0]      i_stat_in,
  output logic            o_im_req,
  output logic [PC_W-1:0] o_im_addr,
  input  logic [IR_W-1:0] i_im_rdata,
  input  logic            i_im_ready,
  output logic [IR_W-1:0] o_ir,
  output logic [3:0]      o_opcode,
  output logic [3:0]      o_mm,
  output logic [15:0]     o_imm,
  output logic [3:0]      o_stat,
  output logic [PC_W-1:0] o_pc_out,
  output logic            o_br_taken,
  output logic            o_fetch_busy,
  output logic            o_fetch_err
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [IR_W-1:0]   r_ir, w_ir_nxt;
  logic              r_err, w_err_nxt;
  logic [PC_W-1:0]   r_addr, w_addr_nxt;
  logic [PC_W-1:0]   r_pc, w_pc_nxt;
  logic [3:0]        r_stat;
  logic [PC_W-1:0]   w_imm, w_target;
  logic [3:0]        w_flags;
  logic              w_br_taken;

  assign w_cnt_inc = r_cnt + CNT_W'(1);

  // Fetch FSM next-state; im_ready wins over a timeout on the same cycle
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ir_nxt    = r_ir;
    w_err_nxt   = r_err;
    w_addr_nxt  = r_addr;
    case (r_state)
      S_IDLE: begin
        if (i_ir_load) begin
          w_addr_nxt  = r_pc;
          w_cnt_nxt   = '0;
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (i_im_ready) begin
          w_ir_nxt    = i_im_rdata;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == CNT_W'(TIMEOUT)) begin
            w_ir_nxt    = '0;
            w_err_nxt   = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Branch condition from registered ir and stat
  assign w_flags = r_stat & r_ir[27:24];
  always_comb begin
    w_br_taken = 1'b0;
    case (r_ir[31:28])
      4'd4, 4'd5: w_br_taken = (r_ir[27:24] == 4'd0) || (|w_flags);
      4'd6, 4'd7: w_br_taken = ~(|w_flags);
      default:    w_br_taken = 1'b0;
    endcase
  end

  assign w_imm    = PC_W'(r_ir[15:0]);
  assign w_target = i_br_sel ? w_imm : (r_pc + w_imm);

  always_comb begin
    w_pc_nxt = r_pc;
    if (i_pc_rst) begin
      w_pc_nxt = '0;
    end else if (i_pc_write) begin
      if (!i_pc_sel)       w_pc_nxt = r_pc + PC_W'(1);
      else if (w_br_taken) w_pc_nxt = w_target;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst_f) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ir    <= '0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_pc    <= '0;
      r_stat  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ir    <= w_ir_nxt;
      r_err   <= w_err_nxt;
      r_addr  <= w_addr_nxt;
      r_pc    <= w_pc_nxt;
      if (i_stat_en) r_stat <= i_stat_in;
    end
  end

  assign o_im_req     = (r_state == S_REQ);
  assign o_im_addr    = r_addr;
  assign o_ir         = r_ir;
  assign o_opcode     = r_ir[31:28];
  assign o_mm         = r_ir[27:24];
  assign o_imm        = r_ir[15:0];
  assign o_stat       = r_stat;
  assign o_pc_out     = r_pc;
  assign o_br_taken   = w_br_taken;
  assign o_fetch_busy = (r_state != S_IDLE);
  assign o_fetch_err  = r_err;

endmodule
